// File: rtl/sys_timer_ctrl_pkg.sv
// Shared definitions for the interval-timer bus master: register map,
// control-word encodings and FSM state type.
package sys_timer_ctrl_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PERIOD_W = 32;

    localparam logic [ADDR_W-1:0] REG_STATUS   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_CONTROL  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_PERIOD_L = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] REG_PERIOD_H = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] REG_SNAP_L   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] REG_SNAP_H   = ADDR_W'(5);

    localparam int unsigned CTRL_ITO_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_STOP_BIT  = 3;

    localparam logic [DATA_W-1:0] CTRL_START_CONT =
        DATA_W'((1 << CTRL_START_BIT) | (1 << CTRL_CONT_BIT) | (1 << CTRL_ITO_BIT));
    localparam logic [DATA_W-1:0] CTRL_START_ONESHOT =
        DATA_W'((1 << CTRL_START_BIT) | (1 << CTRL_ITO_BIT));
    localparam logic [DATA_W-1:0] CTRL_STOP = DATA_W'(1 << CTRL_STOP_BIT);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_CLR,
        ST_WR_STOP,
        ST_SNAP_WR,
        ST_SNAP_RD_L,
        ST_SNAP_RD_H,
        ST_SNAP_CAP
    } state_t;

    // Clamp a requested load value to the minimum supported period.
    function automatic logic [PERIOD_W-1:0] floor_period(input logic [PERIOD_W-1:0] req,
                                                         input logic [PERIOD_W-1:0] min_val);
        return (req < min_val) ? min_val : req;
    endfunction

endpackage

// File: rtl/sys_timer_ctrl_master.sv
// Avalon-MM initiator that programs, services and snapshots the interval timer
// on behalf of fabric logic; every bus access is one registered state cycle.
module sys_timer_ctrl_master
    import sys_timer_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD_MIN = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                snap_req,
    output logic [PERIOD_W-1:0] snap_value,
    output logic                snap_valid,
    output logic                tick,
    output logic [PERIOD_W-1:0] tick_count,
    output logic                running,
    output logic                busy,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write_n,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                irq_in
);

    state_t              state;
    logic                pend_stop;
    logic                pend_snap;
    logic                mode_cont;
    logic [DATA_W-1:0]   period_hi;
    logic [DATA_W-1:0]   snap_lo;
    logic [PERIOD_W-1:0] load_c;

    always_comb begin
        load_c = floor_period(period_in, PERIOD_W'(PERIOD_MIN));
    end

    // Bus strobes default to idle each cycle; each state arms the access of its successor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            pend_stop      <= 1'b0;
            pend_snap      <= 1'b0;
            mode_cont      <= 1'b0;
            period_hi      <= '0;
            snap_lo        <= '0;
            snap_value     <= '0;
            snap_valid     <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            running        <= 1'b0;
            busy           <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            tick           <= 1'b0;
            snap_valid     <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;

            if (state != ST_IDLE) begin
                if (stop)     pend_stop <= 1'b1;
                if (snap_req) pend_snap <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        period_hi      <= load_c[PERIOD_W-1:DATA_W];
                        mode_cont      <= continuous;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_PERIOD_L;
                        avm_writedata  <= load_c[DATA_W-1:0];
                        busy           <= 1'b1;
                        state          <= ST_WR_PL;
                    end
                end
                ST_WR_PL: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_PERIOD_H;
                    avm_writedata  <= period_hi;
                    state          <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_CONTROL;
                    avm_writedata  <= mode_cont ? CTRL_START_CONT : CTRL_START_ONESHOT;
                    tick_count     <= '0;
                    state          <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    running <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (irq_in) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_STATUS;
                        tick           <= 1'b1;
                        tick_count     <= tick_count + PERIOD_W'(1);
                        state          <= ST_CLR;
                    end else if (pend_stop || stop) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_CONTROL;
                        avm_writedata  <= CTRL_STOP;
                        pend_stop      <= 1'b0;
                        state          <= ST_WR_STOP;
                    end else if (pend_snap || snap_req) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_SNAP_L;
                        pend_snap      <= 1'b0;
                        state          <= ST_SNAP_WR;
                    end
                end
                ST_CLR: begin
                    if (mode_cont) begin
                        state <= ST_RUN;
                    end else begin
                        // One-shot timer has already stopped itself; a queued stop is moot.
                        running   <= 1'b0;
                        busy      <= 1'b0;
                        pend_stop <= 1'b0;
                        pend_snap <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_WR_STOP: begin
                    running   <= 1'b0;
                    busy      <= 1'b0;
                    pend_stop <= 1'b0;
                    pend_snap <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_SNAP_WR: begin
                    avm_chipselect <= 1'b1;
                    avm_address    <= REG_SNAP_L;
                    state          <= ST_SNAP_RD_L;
                end
                ST_SNAP_RD_L: begin
                    avm_chipselect <= 1'b1;
                    avm_address    <= REG_SNAP_H;
                    state          <= ST_SNAP_RD_H;
                end
                ST_SNAP_RD_H: begin
                    snap_lo <= avm_readdata;
                    state   <= ST_SNAP_CAP;
                end
                ST_SNAP_CAP: begin
                    snap_value <= {avm_readdata, snap_lo};
                    snap_valid <= 1'b1;
                    state      <= ST_RUN;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
